// File: rtl/int_pkg.sv
// Shared types and constants for the interrupt entry sequencer.
package int_pkg;

  typedef enum logic [1:0] {RESET, NMI, IRQ, BRK} int_src_t;
  typedef enum logic [1:0] {RST, IDLE, SEQ} seq_state_t;

  localparam logic [7:0] VEC_NMI_LO = 8'hFA;
  localparam logic [7:0] VEC_RST_LO = 8'hFC;
  localparam logic [7:0] VEC_IRQ_LO = 8'hFE;

  localparam int STEP_PUSH_PCH = 2;
  localparam int STEP_VEC_LO   = 5;

  function automatic logic [7:0] vec_lo(input int_src_t src);
    case (src)
      NMI:     return VEC_NMI_LO;
      RESET:   return VEC_RST_LO;
      default: return VEC_IRQ_LO;
    endcase
  endfunction

endpackage

// File: rtl/int_edge_detect.sv
// NMI falling-edge pending flag and IRQ level conditioning.
// Define INT_SYNC_EN to put a 2-flop synchronizer in front of nmi_n and irq_n.
module int_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic nmi_n,
  input  logic irq_n,
  input  logic clr,
  output logic nmi_pend,
  output logic irq_lvl_n
);

  logic nmi_s;

`ifdef INT_SYNC_EN
  logic [1:0] nmi_sync_reg;
  logic [1:0] irq_sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nmi_sync_reg <= 2'b11;
      irq_sync_reg <= 2'b11;
    end else begin
      nmi_sync_reg <= {nmi_sync_reg[0], nmi_n};
      irq_sync_reg <= {irq_sync_reg[0], irq_n};
    end
  end

  assign nmi_s     = nmi_sync_reg[1];
  assign irq_lvl_n = irq_sync_reg[1];
`else
  assign nmi_s     = nmi_n;
  assign irq_lvl_n = irq_n;
`endif

  logic nmi_prev_reg;
  logic nmi_pend_reg;
  logic nmi_fall;

  assign nmi_fall = nmi_prev_reg & ~nmi_s;

  // A fresh edge wins over a same-cycle clear so it is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nmi_prev_reg <= 1'b1;
      nmi_pend_reg <= 1'b0;
    end else begin
      nmi_prev_reg <= nmi_s;
      nmi_pend_reg <= nmi_fall | (nmi_pend_reg & ~clr);
    end
  end

  assign nmi_pend = nmi_pend_reg;

endmodule

// File: rtl/interrupt_sequencer.sv
// Exception arbitration and 7-step interrupt entry sequencing (reset/NMI/IRQ/BRK).
// Optional INT_SYNC_EN adds input synchronizers inside int_edge_detect.
module interrupt_sequencer
  import int_pkg::*;
#(
  parameter logic [7:0] VEC_HI  = 8'hFF,
  parameter int         SEQ_LEN = 7,
  parameter int         STEP_W  = 3
) (
  input  logic              ph1,
  input  logic              reset,
  input  logic              nmi_n,
  input  logic              irq_n,
  input  logic              i_flag,
  input  logic              last_cycle,
  input  logic              brk_op,
  output logic              int_take,
  output logic              int_busy,
  output logic [STEP_W-1:0] step,
  output logic              push_en,
  output logic              b_flag,
  output logic              set_i,
  output logic [15:0]       vec_addr,
  output logic              seq_done
);

  localparam logic [STEP_W-1:0] S_PCH  = STEP_W'(STEP_PUSH_PCH);
  localparam logic [STEP_W-1:0] S_P    = STEP_W'(STEP_PUSH_PCH + 2);
  localparam logic [STEP_W-1:0] S_VEC  = STEP_W'(STEP_VEC_LO);
  localparam logic [STEP_W-1:0] S_LAST = STEP_W'(SEQ_LEN - 1);

  seq_state_t        state_reg, state_next;
  int_src_t          src_reg, src_next;
  logic [STEP_W-1:0] step_reg, step_next;

  logic nmi_pend;
  logic irq_s_n;
  logic irq_req;
  logic take_req;
  logic hijack;
  logic nmi_clr;
  logic in_vec_step;

  int_edge_detect u_edge (
    .clk       (ph1),
    .rst_n     (reset),
    .nmi_n     (nmi_n),
    .irq_n     (irq_n),
    .clr       (nmi_clr),
    .nmi_pend  (nmi_pend),
    .irq_lvl_n (irq_s_n)
  );

  assign irq_req     = ~irq_s_n & ~i_flag;
  assign take_req    = last_cycle & (nmi_pend | irq_req);
  assign in_vec_step = (state_reg == SEQ) && (step_reg == S_VEC);
  // A BRK that sees a pending NMI by the vector step fetches the NMI vector instead.
  assign hijack      = (src_reg == BRK) && nmi_pend;
  assign nmi_clr     = in_vec_step && ((src_reg == NMI) || hijack);

  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      state_reg <= RST;
      src_reg   <= RESET;
      step_reg  <= '0;
    end else begin
      state_reg <= state_next;
      src_reg   <= src_next;
      step_reg  <= step_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    src_next   = src_reg;
    step_next  = step_reg;
    case (state_reg)
      RST: begin
        state_next = SEQ;
        src_next   = RESET;
        step_next  = '0;
      end
      IDLE: begin
        if (take_req) begin
          state_next = SEQ;
          src_next   = nmi_pend ? NMI : IRQ;
          step_next  = '0;
        end else if (brk_op) begin
          state_next = SEQ;
          src_next   = BRK;
          step_next  = '0;
        end
      end
      SEQ: begin
        if (in_vec_step && hijack) begin
          src_next = NMI;
        end
        if (step_reg == S_LAST) begin
          state_next = IDLE;
          step_next  = '0;
        end else begin
          step_next = step_reg + STEP_W'(1);
        end
      end
      default: state_next = RST;
    endcase
  end

  always_comb begin
    int_take = 1'b0;
    int_busy = 1'b1;
    step     = '0;
    push_en  = 1'b0;
    b_flag   = 1'b0;
    set_i    = 1'b0;
    vec_addr = 16'h0000;
    seq_done = 1'b0;
    case (state_reg)
      IDLE: begin
        int_busy = 1'b0;
        int_take = take_req;
      end
      SEQ: begin
        step    = step_reg;
        push_en = (step_reg >= S_PCH) && (step_reg <= S_P) && (src_reg != RESET);
        b_flag  = (step_reg == S_P) && (src_reg == BRK);
        if (step_reg == S_VEC) begin
          set_i    = 1'b1;
          vec_addr = {VEC_HI, vec_lo(hijack ? NMI : src_reg)};
        end
        if (step_reg == S_LAST) begin
          seq_done = 1'b1;
          vec_addr = {VEC_HI, vec_lo(src_reg) + 8'd1};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer with a cycle model of the entry rules.
module tb_interrupt_sequencer;

  logic        ph1 = 1'b0;
  logic        reset, nmi_n, irq_n, i_flag, last_cycle, brk_op;
  logic        int_take, int_busy, push_en, b_flag, set_i, seq_done;
  logic [2:0]  step;
  logic [15:0] vec_addr;

  int n_checks = 0;
  int n_pass   = 0;

  interrupt_sequencer dut (
    .ph1        (ph1),
    .reset      (reset),
    .nmi_n      (nmi_n),
    .irq_n      (irq_n),
    .i_flag     (i_flag),
    .last_cycle (last_cycle),
    .brk_op     (brk_op),
    .int_take   (int_take),
    .int_busy   (int_busy),
    .step       (step),
    .push_en    (push_en),
    .b_flag     (b_flag),
    .set_i      (set_i),
    .vec_addr   (vec_addr),
    .seq_done   (seq_done)
  );

  always #5 ph1 = ~ph1;

  localparam int M_RESET = 0, M_NMI = 1, M_IRQ = 2, M_BRK = 3;

  // Model: m_pos = -2 reset, -1 idle, 0..6 sequence step.
  int m_pos  = -2;
  int m_src  = M_RESET;
  bit m_pend = 1'b0;
  bit m_prev = 1'b1;

  int          p;
  bit          fall, clr;
  logic        e_take;
  logic [15:0] e_vec;

  function automatic logic [15:0] vec_of(input int s);
    case (s)
      M_NMI:   return 16'hFFFA;
      M_RESET: return 16'hFFFC;
      default: return 16'hFFFE;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
  endtask

  task automatic nxt();
    @(negedge ph1);
  endtask

  // Compare every cycle mid-low-phase, then advance the model on the rising edge.
  initial begin
    #2;
    forever begin
      @(negedge ph1);
      #2;
      p      = reset ? m_pos : -2;
      e_take = (p == -1) && last_cycle && (m_pend || (!irq_n && !i_flag));
      e_vec  = 16'h0000;
      if (p == 5) e_vec = vec_of((m_src == M_BRK && m_pend) ? M_NMI : m_src);
      if (p == 6) e_vec = vec_of(m_src) + 16'd1;
      chk("int_take", int_take, e_take);
      chk("int_busy", int_busy, p != -1);
      chk("step",     step,     (p >= 0) ? p : 0);
      chk("push_en",  push_en,  (p >= 2) && (p <= 4) && (m_src != M_RESET));
      chk("b_flag",   b_flag,   (p == 4) && (m_src == M_BRK));
      chk("set_i",    set_i,    p == 5);
      chk("vec_addr", vec_addr, e_vec);
      chk("seq_done", seq_done, p == 6);

      @(posedge ph1);
      if (!reset) begin
        m_pos  = -2;
        m_src  = M_RESET;
        m_pend = 1'b0;
        m_prev = 1'b1;
      end else begin
        fall   = m_prev && !nmi_n;
        m_prev = nmi_n;
        clr    = 1'b0;
        if (m_pos == -2) begin
          m_pos = 0;
          m_src = M_RESET;
        end else if (m_pos == -1) begin
          if (last_cycle && (m_pend || (!irq_n && !i_flag))) begin
            m_pos = 0;
            m_src = m_pend ? M_NMI : M_IRQ;
          end else if (brk_op) begin
            m_pos = 0;
            m_src = M_BRK;
          end
        end else begin
          if (m_pos == 5) begin
            if (m_src == M_BRK && m_pend) m_src = M_NMI;
            clr = (m_src == M_NMI);
          end
          m_pos = (m_pos == 6) ? -1 : m_pos + 1;
        end
        m_pend = fall || (m_pend && !clr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; nmi_n = 1'b1; irq_n = 1'b1; i_flag = 1'b1;
    last_cycle = 1'b0; brk_op = 1'b0;
    #1 reset = 1'b0;

    // Reset release: full reset sequence with no pushes.
    repeat (3) nxt();
    #3 chk("rst_busy", int_busy, 1); chk("rst_vec", vec_addr, 0);
    nxt(); reset = 1'b1;
    nxt(); #3 chk("rel_s0_step", step, 0); chk("rel_s0_busy", int_busy, 1);
    repeat (5) nxt();
    #3 chk("rel_vec5", vec_addr, 16'hFFFC);
    nxt(); #3 chk("rel_vec6", vec_addr, 16'hFFFD); chk("rel_done", seq_done, 1);
    nxt(); #3 chk("rel_idle", int_busy, 0);

    // IRQ taken, then masked by I.
    nxt(); irq_n = 1'b0; i_flag = 1'b0; last_cycle = 1'b1;
    #3 chk("irq_take", int_take, 1);
    nxt(); irq_n = 1'b1; last_cycle = 1'b0;
    nxt(); nxt(); #3 chk("irq_push", push_en, 1);
    nxt(); brk_op = 1'b1; last_cycle = 1'b1;
    nxt(); brk_op = 1'b0; last_cycle = 1'b0; #3 chk("irq_bflag", b_flag, 0);
    nxt(); #3 chk("irq_vec5", vec_addr, 16'hFFFE); chk("irq_seti", set_i, 1);
    nxt(); #3 chk("irq_vec6", vec_addr, 16'hFFFF);
    nxt(); irq_n = 1'b0; i_flag = 1'b1; last_cycle = 1'b1;
    #3 chk("irq_masked", int_take, 0);
    nxt(); irq_n = 1'b1; last_cycle = 1'b0; #3 chk("masked_idle", int_busy, 0);

    // NMI beats IRQ; IRQ follows at the next boundary.
    nxt(); nmi_n = 1'b0; irq_n = 1'b0; i_flag = 1'b0;
    nxt(); last_cycle = 1'b1; #3 chk("nmi_take", int_take, 1);
    nxt(); last_cycle = 1'b0; nmi_n = 1'b1;
    repeat (5) nxt();
    #3 chk("nmi_vec5", vec_addr, 16'hFFFA);
    nxt(); #3 chk("nmi_vec6", vec_addr, 16'hFFFB);
    nxt(); last_cycle = 1'b1; #3 chk("irq_after_nmi", int_take, 1);
    nxt(); last_cycle = 1'b0; irq_n = 1'b1; i_flag = 1'b1;
    repeat (5) nxt();
    #3 chk("irq_after_vec5", vec_addr, 16'hFFFE);
    nxt(); nxt();

    // BRK hijacked by an NMI arriving in S2.
    brk_op = 1'b1; #3 chk("brk_no_take", int_take, 0);
    nxt(); brk_op = 1'b0;
    nxt();
    nxt(); nmi_n = 1'b0;
    nxt();
    nxt(); #3 chk("brk_bflag", b_flag, 1);
    nxt(); #3 chk("brk_hijack_vec", vec_addr, 16'hFFFA);
    nxt(); nmi_n = 1'b1; #3 chk("brk_hijack_vec6", vec_addr, 16'hFFFB);
    nxt(); last_cycle = 1'b1; #3 chk("brk_pend_clr", int_take, 0);

    // NMI edge during S6 of an IRQ sequence is taken afterwards.
    nxt(); irq_n = 1'b0; i_flag = 1'b0; #3 chk("irq2_take", int_take, 1);
    nxt(); last_cycle = 1'b0; irq_n = 1'b1; i_flag = 1'b1;
    repeat (6) nxt();
    nmi_n = 1'b0; #3 chk("irq2_s6", seq_done, 1);
    nxt(); #3 chk("irq2_idle", int_busy, 0);
    nxt(); last_cycle = 1'b1; #3 chk("late_nmi_take", int_take, 1);

    // Reset at S3 of that NMI sequence drops the pending NMI.
    nxt(); last_cycle = 1'b0;
    nxt(); nxt(); nxt();
    reset = 1'b0; nmi_n = 1'b1;
    #3 chk("abort_push", push_en, 0); chk("abort_busy", int_busy, 1); chk("abort_step", step, 0);
    nxt(); nxt();
    reset = 1'b1;
    repeat (6) nxt();
    #3 chk("abort_vec5", vec_addr, 16'hFFFC);
    nxt(); nxt(); last_cycle = 1'b1; #3 chk("pend_lost", int_take, 0);
    nxt(); last_cycle = 1'b0;
    nxt(); nxt();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Arbitrates the CPU's exception sources (reset, NMI, IRQ, BRK) and sequences the 7-cycle interrupt entry.
- Sits beside `control`. At an instruction boundary it forces the opcode latch to BRK (0x00) via `int_take`.
- It then steps the push/vector-fetch cycles and supplies vector address, push enable, B-flag value and I-flag set to the datapath.

Parameters:
- VEC_HI, 8'hFF: high byte of all vector addresses.
- SEQ_LEN, 7: number of cycles in the entry sequence, S0..S6.
- STEP_W, 3: width of the step counter. Must satisfy 2^STEP_W >= SEQ_LEN.

Ports:
- ph1  in  1  system clock (single clock; all state updates on rising edge)
- reset  in  1  asynchronous, active-low reset
- nmi_n  in  1  NMI request, falling-edge sensitive
- irq_n  in  1  IRQ request, level sensitive, active-low
- i_flag  in  1  current P register I bit
- last_cycle  in  1  control FSM is in the final cycle of an instruction
- brk_op  in  1  decoded opcode is BRK (valid in the instruction's first cycle)
- int_take  out  1  one-cycle pulse: control substitutes opcode 0x00 for the fetched byte
- int_busy  out  1  entry sequence in progress
- step  out  STEP_W  current sequence step, 0..6
- push_en  out  1  stack write enable for steps 2–4
- b_flag  out  1  value of B bit written with P in step 4
- set_i  out  1  set the I flag (step 5)
- vec_addr  out  16  vector fetch address (steps 5 and 6); 0 otherwise
- seq_done  out  1  one-cycle pulse in step 6

Behaviour:
- **Reset.** While reset is low:
  - state=RST; nmi_pend=0; src=RESET.
  - All outputs 0, except int_busy=1.
- **After reset.** On the first clock after reset goes high, go to SEQ at S0 with src=RESET. No int_take is issued.
- **States.**
  - IDLE → SEQ on a taken request.
  - SEQ steps S0→S6, one per clock, then returns to IDLE.
  - RST → SEQ.
- **NMI detection.** nmi_n is registered once. nmi_pend is set when the registered value is 1 and the current value is 0. It is cleared in S5 of a sequence whose src=NMI. A new falling edge arriving at or after S5 re-sets nmi_pend.
- **IRQ.** irq_req = ~irq_n & ~i_flag, sampled combinationally. No latching.
- **Taking a request.** In IDLE, with last_cycle=1 and (nmi_pend | irq_req):
  - Assert int_take for that cycle.
  - Latch src: NMI has priority over IRQ.
  - Next cycle: SEQ S0.
- **BRK.** In IDLE, brk_op=1 with int_take=0 enters SEQ S0 next cycle with src=BRK and no int_take.
- **BRK hijack.** If nmi_pend is set by S4 of a BRK sequence, the vector becomes NMI. b_flag stays 1 and nmi_pend clears in S5.
- **Step outputs.**
  - S0, S1: dummy reads.
  - S2 / S3 / S4: push PCH / PCL / P. push_en=1, except when src=RESET, where push_en=0 (stack reads only).
  - b_flag=1 only for src=BRK in S4.
  - S5: set_i=1; vec_addr = {VEC_HI, lo}, with lo = 8'hFA for NMI, 8'hFC for RESET, 8'hFE for IRQ/BRK.
  - S6: vec_addr low byte + 1; seq_done=1.
- **int_busy.** int_busy=1 in RST and all SEQ steps.
- **Requests during SEQ.** last_cycle and brk_op are ignored while in SEQ. IRQ is re-evaluated at the next boundary; because I is set, it is masked unless software clears I.
- **Reset mid-sequence.** Asynchronously abort to RST. The pending NMI is discarded.

Optional Feature:
- Macro: INT_SYNC_EN.
- When defined, nmi_n and irq_n each pass through a 2-flop synchronizer (reset value 1) before edge/level logic. Detection latency grows by 2 cycles.
- When undefined, the inputs are used directly; nmi_n still gets the single edge-detect register.

Decomposition:
- Shared package int_pkg holds:
  - typedef enum int_src_t {RESET, NMI, IRQ, BRK};
  - typedef enum seq_state_t {RST, IDLE, SEQ};
  - constants VEC_NMI_LO=8'hFA, VEC_RST_LO=8'hFC, VEC_IRQ_LO=8'hFE, STEP_PUSH_PCH=2, STEP_VEC_LO=5.
- One natural sub-module: int_edge_detect. It contains the optional synchronizer plus the NMI falling-edge pending flag, with a clear input.

Test Plan:
- **Reset release.** Hold reset low 3 cycles, then release → int_busy=1; S0..S6 run over 7 cycles; push_en never 1; vec_addr=16'hFFFC in S5 and 16'hFFFD in S6; seq_done pulses once; then IDLE with int_busy=0.
- **IRQ taken and masked.**
  - irq_n=0, i_flag=0, last_cycle=1 → int_take pulses that cycle; push_en=1 in S2–S4; b_flag=0; vec_addr=16'hFFFE/16'hFFFF; set_i=1 in S5.
  - Same stimulus with i_flag=1 → no int_take.
- **NMI beats IRQ.** NMI falling edge and irq_n=0, then last_cycle=1 → src=NMI, vec_addr=16'hFFFA; nmi_pend clears at S5; next boundary (i_flag=0) takes IRQ.
- **BRK hijack.** brk_op=1 in IDLE, then nmi_n falls during S2 → S4 b_flag=1; S5 vec_addr=16'hFFFA.
- **NMI during sequence.** During an IRQ sequence, an NMI edge at S6 → nmi_pend=1 after return to IDLE; taken at the next last_cycle.
- **Reset mid-sequence.** Assert reset at S3 → all outputs 0 immediately (int_busy=1); pending NMI lost; after release, the reset sequence runs with vec_addr=16'hFFFC.
